// File: rtl/cpc_mem_arbiter.sv
// Slot scheduler sharing the SDRAM CPU port between CPU, boot download FIFO and DMA.
// Optional macro ARB_STARVE_EN adds a DMA anti-starvation counter.
module cpc_mem_arbiter #(
    parameter int BOOT_DEPTH = 4,
    parameter int RD_SLOTS   = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        boot_mode,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [1:0]  cpu_bank,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_busy,
    input  logic        boot_wr,
    input  logic [22:0] boot_addr,
    input  logic [1:0]  boot_bank,
    input  logic [7:0]  boot_din,
    output logic        boot_full,
    output logic        boot_ovf,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [22:0] dma_addr,
    input  logic [1:0]  dma_bank,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout
);

    localparam int PW = $clog2(BOOT_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(BOOT_DEPTH);

    typedef enum logic [1:0] {SEL_NONE, SEL_CPU, SEL_BOOT, SEL_DMA} sel_t;

    sel_t        sel;
    logic        cpu_rd_q, cpu_wr_q;
    logic        cpu_pend, cpu_pend_we, cpu_busy_q;
    logic [22:0] cpu_pend_addr;
    logic [1:0]  cpu_pend_bank;
    logic [7:0]  cpu_pend_din;
    logic        rd_rise, wr_rise;

    logic [32:0] fifo_mem [BOOT_DEPTH];
    logic [32:0] fifo_head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic        push_ok, pop;

    logic        dma_busy, dma_ok, dma_force, cpu_ok, boot_ok;
    logic        gnt_we;
    logic [22:0] gnt_addr;
    logic [1:0]  gnt_bank;
    logic [7:0]  gnt_din;

    logic [RD_SLOTS-1:0] pipe_vld, pipe_dma;
    logic        cap, cap_cpu, cap_dma, rd_grant;

    assign rd_rise   = cpu_rd && !cpu_rd_q;
    assign wr_rise   = cpu_wr && !cpu_wr_q;
    assign cpu_busy  = cpu_busy_q;
    assign boot_full = (count == DEPTH_C);
    assign fifo_head = fifo_mem[rd_ptr];

    assign cpu_ok  = cpu_pend && !boot_mode;
    assign boot_ok = (count != '0);
    assign dma_ok  = dma_req && !dma_busy;

    assign pop     = (sel == SEL_BOOT);
    assign push_ok = boot_wr && (!boot_full || pop);

    assign cap      = ce_ref && pipe_vld[RD_SLOTS-1];
    assign cap_cpu  = cap && !pipe_dma[RD_SLOTS-1];
    assign cap_dma  = cap && pipe_dma[RD_SLOTS-1];
    assign rd_grant = (sel != SEL_NONE) && !gnt_we;

`ifdef ARB_STARVE_EN
    logic [3:0] starve_cnt;

    assign dma_force = (starve_cnt >= 4'(STARVE_MAX));

    always_ff @(posedge clk_sys) begin
        if (reset || !dma_req)
            starve_cnt <= '0;
        else if (sel == SEL_DMA)
            starve_cnt <= '0;
        else if (ce_ref && dma_ok && starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    // Strict priority: the DMA engine is never promoted.
    assign dma_force = (STARVE_MAX < 0);
`endif

    always_comb begin
        sel = SEL_NONE;
        if (ce_ref) begin
            if (dma_force && dma_ok)
                sel = SEL_DMA;
            else if (cpu_ok)
                sel = SEL_CPU;
            else if (boot_ok)
                sel = SEL_BOOT;
            else if (dma_ok)
                sel = SEL_DMA;
        end
    end

    always_comb begin
        gnt_we   = 1'b0;
        gnt_addr = mem_addr;
        gnt_bank = mem_bank;
        gnt_din  = mem_din;
        case (sel)
            SEL_CPU: begin
                gnt_we   = cpu_pend_we;
                gnt_addr = cpu_pend_addr;
                gnt_bank = cpu_pend_bank;
                gnt_din  = cpu_pend_din;
            end
            SEL_BOOT: begin
                gnt_we   = 1'b1;
                gnt_addr = fifo_head[32:10];
                gnt_bank = fifo_head[9:8];
                gnt_din  = fifo_head[7:0];
            end
            SEL_DMA: begin
                gnt_we   = dma_we;
                gnt_addr = dma_addr;
                gnt_bank = dma_bank;
                gnt_din  = dma_din;
            end
            default: ;
        endcase
    end

    // A read or write stays busy until its write slot or its read data capture.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_rd_q      <= 1'b0;
            cpu_wr_q      <= 1'b0;
            cpu_pend      <= 1'b0;
            cpu_pend_we   <= 1'b0;
            cpu_busy_q    <= 1'b0;
            cpu_pend_addr <= '0;
            cpu_pend_bank <= '0;
            cpu_pend_din  <= '0;
            cpu_rdata     <= '0;
        end else begin
            cpu_rd_q <= cpu_rd;
            cpu_wr_q <= cpu_wr;
            if (sel == SEL_CPU) begin
                cpu_pend <= 1'b0;
                if (cpu_pend_we)
                    cpu_busy_q <= 1'b0;
            end
            if (cap_cpu) begin
                cpu_rdata  <= mem_dout;
                cpu_busy_q <= 1'b0;
            end
            if (!cpu_busy_q && (rd_rise || wr_rise)) begin
                cpu_pend      <= 1'b1;
                cpu_busy_q    <= 1'b1;
                cpu_pend_we   <= !rd_rise;
                cpu_pend_addr <= cpu_addr;
                cpu_pend_bank <= cpu_bank;
                cpu_pend_din  <= cpu_din;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= {boot_addr, boot_bank, boot_din};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            boot_ovf <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW + 1)'(push_ok) - (PW + 1)'(pop);
            if (boot_wr && !push_ok)
                boot_ovf <= 1'b1;
        end
    end

    // dma_busy blocks re-granting a request whose ack has not yet been seen.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dma_busy  <= 1'b0;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
        end else begin
            dma_ack <= ((sel == SEL_DMA) && gnt_we) || cap_dma;
            if (cap_dma)
                dma_rdata <= mem_dout;
            if (dma_ack)
                dma_busy <= 1'b0;
            if (sel == SEL_DMA)
                dma_busy <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pipe_vld <= '0;
            pipe_dma <= '0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_bank <= '0;
            mem_din  <= '0;
        end else if (ce_ref) begin
            pipe_vld <= (pipe_vld << 1) | RD_SLOTS'(rd_grant);
            pipe_dma <= (pipe_dma << 1) | RD_SLOTS'(rd_grant && (sel == SEL_DMA));
            mem_oe   <= rd_grant;
            mem_we   <= (sel != SEL_NONE) && gnt_we;
            mem_addr <= gnt_addr;
            mem_bank <= gnt_bank;
            mem_din  <= gnt_din;
        end
    end

endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// Directed bench for cpc_mem_arbiter; honours ARB_STARVE_EN for the starvation case.
module tb_cpc_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset, ce_ref, boot_mode;
    logic        cpu_rd, cpu_wr;
    logic [22:0] cpu_addr;
    logic [1:0]  cpu_bank;
    logic [7:0]  cpu_din, cpu_rdata;
    logic        cpu_busy;
    logic        boot_wr;
    logic [22:0] boot_addr;
    logic [1:0]  boot_bank;
    logic [7:0]  boot_din;
    logic        boot_full, boot_ovf;
    logic        dma_req, dma_we;
    logic [22:0] dma_addr;
    logic [1:0]  dma_bank;
    logic [7:0]  dma_din;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        mem_oe, mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_din, mem_dout;

    int vectors = 0;
    int miscompares = 0;

`ifdef ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    always #5 clk_sys = ~clk_sys;

    cpc_mem_arbiter dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref), .boot_mode(boot_mode),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
        .cpu_din(cpu_din), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .boot_wr(boot_wr), .boot_addr(boot_addr), .boot_bank(boot_bank), .boot_din(boot_din),
        .boot_full(boot_full), .boot_ovf(boot_ovf),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_bank(dma_bank),
        .dma_din(dma_din), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_bank(mem_bank),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One ce_ref slot; outputs registered on that slot are visible on return.
    task automatic applyStimulus();
        ce_ref = 1'b1;
        tick();
        ce_ref = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; ce_ref = 1'b0; boot_mode = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_bank = '0; cpu_din = '0;
        boot_wr = 1'b0; boot_addr = '0; boot_bank = '0; boot_din = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_bank = '0; dma_din = '0;
        mem_dout = '0;
        idle(3);
        checkOutput("rst_mem_oe", 32'(mem_oe), 0);
        checkOutput("rst_mem_we", 32'(mem_we), 0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 0);
        checkOutput("rst_cpu_busy", 32'(cpu_busy), 0);
        checkOutput("rst_boot_full", 32'(boot_full), 0);
        checkOutput("rst_dma_ack", 32'(dma_ack), 0);
        reset = 1'b0;
        tick();

        $display("[TB] single CPU read");
        cpu_addr = 23'h000123; cpu_bank = 2'd1; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0; mem_dout = 8'hA5;
        checkOutput("rd_busy_set", 32'(cpu_busy), 1);
        checkOutput("rd_no_slot_yet", 32'(mem_oe), 0);
        applyStimulus();
        checkOutput("rd_grant_oe", 32'(mem_oe), 1);
        checkOutput("rd_grant_we", 32'(mem_we), 0);
        checkOutput("rd_grant_addr", 32'(mem_addr), 32'h123);
        checkOutput("rd_grant_bank", 32'(mem_bank), 1);
        idle(15);
        applyStimulus();
        checkOutput("rd_slot1_oe", 32'(mem_oe), 0);
        checkOutput("rd_slot1_busy", 32'(cpu_busy), 1);
        checkOutput("rd_slot1_rdata", 32'(cpu_rdata), 0);
        idle(15);
        applyStimulus();
        checkOutput("rd_slot2_rdata", 32'(cpu_rdata), 32'hA5);
        checkOutput("rd_slot2_busy", 32'(cpu_busy), 0);
        checkOutput("rd_addr_hold", 32'(mem_addr), 32'h123);
        idle(15);

        $display("[TB] boot FIFO overflow and drain");
        for (int i = 0; i < 6; i++) begin
            boot_wr = 1'b1; boot_addr = 23'(32'h100 + i); boot_bank = 2'd2; boot_din = 8'(8'h10 + i);
            tick();
            if (i == 3) begin
                checkOutput("boot_full_at4", 32'(boot_full), 1);
                checkOutput("boot_ovf_at4", 32'(boot_ovf), 0);
            end
        end
        boot_wr = 1'b0;
        checkOutput("boot_full_after6", 32'(boot_full), 1);
        checkOutput("boot_ovf_after6", 32'(boot_ovf), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("boot_drain_we", 32'(mem_we), 1);
            checkOutput("boot_drain_addr", 32'(mem_addr), 32'h100 + i);
            checkOutput("boot_drain_din", 32'(mem_din), 32'h10 + i);
            checkOutput("boot_drain_bank", 32'(mem_bank), 2);
            idle(15);
        end
        checkOutput("boot_empty_full", 32'(boot_full), 0);
        applyStimulus();
        checkOutput("boot_fifo_empty_we", 32'(mem_we), 0);
        checkOutput("boot_fifo_empty_addr", 32'(mem_addr), 32'h103);
        idle(15);

        $display("[TB] CPU, boot and DMA together");
        cpu_addr = 23'h200; cpu_bank = 2'd0; cpu_din = 8'h11; cpu_wr = 1'b1;
        boot_wr = 1'b1; boot_addr = 23'h300; boot_din = 8'h22;
        tick();
        cpu_wr = 1'b0; boot_wr = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h400; dma_bank = 2'd3; dma_din = 8'h33;
        applyStimulus();
        checkOutput("pri1_addr", 32'(mem_addr), 32'h200);
        checkOutput("pri1_din", 32'(mem_din), 32'h11);
        checkOutput("pri1_we", 32'(mem_we), 1);
        checkOutput("pri1_cpu_busy", 32'(cpu_busy), 0);
        checkOutput("pri1_dma_ack", 32'(dma_ack), 0);
        idle(15);
        applyStimulus();
        checkOutput("pri2_addr", 32'(mem_addr), 32'h300);
        checkOutput("pri2_din", 32'(mem_din), 32'h22);
        idle(15);
        applyStimulus();
        checkOutput("pri3_addr", 32'(mem_addr), 32'h400);
        checkOutput("pri3_bank", 32'(mem_bank), 3);
        checkOutput("pri3_dma_ack", 32'(dma_ack), 1);
        dma_req = 1'b0;
        tick();
        checkOutput("pri3_ack_pulse", 32'(dma_ack), 0);
        idle(14);

        $display("[TB] boot_mode holds CPU");
        boot_mode = 1'b1;
        cpu_addr = 23'h500; cpu_din = 8'h44; cpu_wr = 1'b1;
        boot_wr = 1'b1; boot_addr = 23'h600; boot_din = 8'h55;
        tick();
        cpu_wr = 1'b0; boot_addr = 23'h601; boot_din = 8'h56;
        tick();
        boot_wr = 1'b0;
        checkOutput("bm_cpu_busy", 32'(cpu_busy), 1);
        applyStimulus();
        checkOutput("bm_boot0", 32'(mem_addr), 32'h600);
        idle(15);
        applyStimulus();
        checkOutput("bm_boot1", 32'(mem_addr), 32'h601);
        idle(15);
        applyStimulus();
        checkOutput("bm_hold_we", 32'(mem_we), 0);
        checkOutput("bm_hold_busy", 32'(cpu_busy), 1);
        idle(15);
        boot_mode = 1'b0;
        applyStimulus();
        checkOutput("bm_cpu_addr", 32'(mem_addr), 32'h500);
        checkOutput("bm_cpu_din", 32'(mem_din), 32'h44);
        checkOutput("bm_cpu_we", 32'(mem_we), 1);
        checkOutput("bm_cpu_done", 32'(cpu_busy), 0);
        idle(15);

        $display("[TB] DMA read");
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h700; mem_dout = 8'h5A;
        applyStimulus();
        checkOutput("dmard_oe", 32'(mem_oe), 1);
        checkOutput("dmard_addr", 32'(mem_addr), 32'h700);
        checkOutput("dmard_no_ack", 32'(dma_ack), 0);
        idle(15);
        applyStimulus();
        checkOutput("dmard_no_regrant", 32'(mem_oe), 0);
        idle(15);
        applyStimulus();
        checkOutput("dmard_ack", 32'(dma_ack), 1);
        checkOutput("dmard_rdata", 32'(dma_rdata), 32'h5A);
        checkOutput("dmard_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        dma_req = 1'b0;
        tick();
        checkOutput("dmard_ack_pulse", 32'(dma_ack), 0);
        idle(14);

        $display("[TB] DMA under continuous CPU traffic");
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h7FF; dma_din = 8'h77;
        for (int i = 1; i <= 9; i++) begin
            cpu_addr = 23'(32'h10 + i); cpu_din = 8'(i); cpu_wr = 1'b1;
            tick();
            cpu_wr = 1'b0;
            tick();
            applyStimulus();
            if (STARVE && i == 9) begin
                checkOutput("starve_dma_addr", 32'(mem_addr), 32'h7FF);
                checkOutput("starve_dma_ack", 32'(dma_ack), 1);
            end else begin
                checkOutput("starve_cpu_addr", 32'(mem_addr), 32'h10 + i);
                checkOutput("starve_no_ack", 32'(dma_ack), 0);
            end
            idle(12);
        end
        dma_req = 1'b0;
        applyStimulus();
        checkOutput("starve_cpu_drained", 32'(cpu_busy), 0);
        checkOutput("starve_final_ack", 32'(dma_ack), 0);
        idle(15);

        $display("[TB] reset during read");
        cpu_addr = 23'h123; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0; mem_dout = 8'hEE;
        applyStimulus();
        checkOutput("rstrd_oe", 32'(mem_oe), 1);
        idle(15);
        applyStimulus();
        idle(5);
        reset = 1'b1;
        tick();
        checkOutput("rstrd_mem_oe", 32'(mem_oe), 0);
        checkOutput("rstrd_mem_addr", 32'(mem_addr), 0);
        checkOutput("rstrd_mem_bank", 32'(mem_bank), 0);
        checkOutput("rstrd_mem_din", 32'(mem_din), 0);
        checkOutput("rstrd_cpu_busy", 32'(cpu_busy), 0);
        checkOutput("rstrd_cpu_rdata", 32'(cpu_rdata), 0);
        checkOutput("rstrd_dma_rdata", 32'(dma_rdata), 0);
        checkOutput("rstrd_boot_ovf", 32'(boot_ovf), 0);
        reset = 1'b0;
        idle(9);
        applyStimulus();
        checkOutput("rstrd_no_capture", 32'(cpu_rdata), 0);
        checkOutput("rstrd_no_ack", 32'(dma_ack), 0);
        checkOutput("rstrd_idle_oe", 32'(mem_oe), 0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
